fc_layer_seq: RTL and testbench

Parametrised, time-multiplexed fully connected layer for the DNN datapath. It accepts one input vector and a full weight matrix per transaction and computes N_OUT signed dot products of length N_IN. A single multiply-accumulate unit does this work sequentially, with optional ReLU. Each neuron raises its own ready flag as it finishes, and the block also has a vector-level valid/ready output handshake. Instances chain directly: layer k's `y` and `out_valid` feed layer k+1's `x` and `in_valid`.

---
 rtl/fc_pkg.sv | 32 +++
 rtl/fc_mac.sv | 25 ++
 rtl/fc_layer_seq.sv | 141 ++++++++++++++
 tb/tb_fc_layer_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and helpers for the time-multiplexed fully connected layer.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fc_state_e;

    // Working width of the activation helper; OW of any instance must not exceed it.
    localparam int FC_ACT_W = 64;

    // Output/accumulator width: product width plus growth for an N_IN-term sum.
    function automatic int fc_ow(input int n_in, input int iw, input int ww);
        return iw + ww + $clog2(n_in);
    endfunction

    // Optional ReLU: clamp negative values to zero when enabled.
    function automatic logic signed [FC_ACT_W-1:0] fc_act(
        input logic signed [FC_ACT_W-1:0] v,
        input logic                       relu_en
    );
        logic signed [FC_ACT_W-1:0] r;
        if (relu_en && (v < $signed(64'sd0))) begin
            r = '0;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/fc_mac.sv
// Combinational signed multiply-accumulate step: sum = acc + x_el * w_el.
module fc_mac
    import fc_pkg::*;
#(
    parameter int IW = 5,
    parameter int WW = 5,
    parameter int OW = 12
) (
    input  logic signed [IW-1:0] x_el,
    input  logic signed [WW-1:0] w_el,
    input  logic signed [OW-1:0] acc,
    output logic signed [OW-1:0] sum
);

    logic signed [IW+WW-1:0] prod_s;
    logic signed [OW-1:0]    prod_ext_s;

    // Full-precision product, sign-extended to the accumulator width, then added.
    always_comb begin
        prod_s     = (IW+WW)'(x_el) * (IW+WW)'(w_el);
        prod_ext_s = {{(OW-IW-WW){prod_s[IW+WW-1]}}, prod_s};
        sum        = acc + prod_ext_s;
    end

endmodule

// File: rtl/fc_layer_seq.sv
// Fully connected layer computed one MAC per cycle with per-neuron done flags
// and a vector-level valid/ready output handshake.
module fc_layer_seq
    import fc_pkg::*;
#(
    parameter  int N_IN  = 4,
    parameter  int N_OUT = 4,
    parameter  int IW    = 5,
    parameter  int WW    = 5,
    parameter  int RELU  = 1,
    localparam int OW    = fc_ow(N_IN, IW, WW)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_IN*IW-1:0]          x,
    input  logic [N_IN*N_OUT*WW-1:0]    w,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [N_OUT*OW-1:0]         y,
    output logic [N_OUT-1:0]            y_vld,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int IB = $clog2(N_IN);
    localparam int OB = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    fc_state_e                  state_r;
    logic [N_IN*IW-1:0]         x_q_r;
    logic [N_IN*N_OUT*WW-1:0]   w_q_r;
    logic signed [OW-1:0]       acc_r;
    logic [IB-1:0]              i_r;
    logic [OB-1:0]              o_r;
    logic [OW-1:0]              y_arr_r [N_OUT];
    logic [N_OUT-1:0]           y_vld_r;
    logic                       in_ready_r;
    logic                       out_valid_r;

    logic signed [IW-1:0]       x_el_s;
    logic signed [WW-1:0]       w_el_s;
    logic signed [OW-1:0]       sum_s;
    logic signed [FC_ACT_W-1:0] act_full_s;
    logic [OW-1:0]              act_s;

    // Pick the operands for the current (neuron, input) position from the frozen copies.
    always_comb begin
        x_el_s = x_q_r[int'(i_r)*IW +: IW];
        w_el_s = w_q_r[(int'(o_r)*N_IN + int'(i_r))*WW +: WW];
    end

    fc_mac #(
        .IW (IW),
        .WW (WW),
        .OW (OW)
    ) u_mac (
        .x_el (x_el_s),
        .w_el (w_el_s),
        .acc  (acc_r),
        .sum  (sum_s)
    );

    // Activation of the completed dot product (acc plus the last product).
    always_comb begin
        act_full_s = fc_act(FC_ACT_W'(sum_s), RELU != 0);
        act_s      = act_full_s[OW-1:0];
    end

    // Control FSM and all datapath registers; outputs are register copies only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            x_q_r       <= '0;
            w_q_r       <= '0;
            acc_r       <= '0;
            i_r         <= '0;
            o_r         <= '0;
            y_vld_r     <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            for (int k = 0; k < N_OUT; k++) begin
                y_arr_r[k] <= '0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        x_q_r      <= x;
                        w_q_r      <= w;
                        acc_r      <= '0;
                        i_r        <= '0;
                        o_r        <= '0;
                        y_vld_r    <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    if (i_r == IB'(N_IN-1)) begin
                        y_arr_r[o_r] <= act_s;
                        y_vld_r[o_r] <= 1'b1;
                        acc_r        <= '0;
                        i_r          <= '0;
                        if (o_r == OB'(N_OUT-1)) begin
                            out_valid_r <= 1'b1;
                            state_r     <= HOLD;
                        end else begin
                            o_r <= o_r + OB'(1);
                        end
                    end else begin
                        acc_r <= sum_s;
                        i_r   <= i_r + IB'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        y_vld_r     <= '0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    y_vld_r     <= '0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // Flatten the per-neuron result registers onto the output bus.
    for (genvar g = 0; g < N_OUT; g++) begin : g_y
        assign y[g*OW +: OW] = y_arr_r[g];
    end

    assign y_vld     = y_vld_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Self-checking bench: two layer instances (ReLU on / off) share one stimulus
// stream; results are compared against a plain dot-product reference model.
module tb_fc_layer_seq;

    localparam int N_IN  = 4;
    localparam int N_OUT = 4;
    localparam int IW    = 5;
    localparam int WW    = 5;
    localparam int OW    = 12;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N_IN*IW-1:0]       x;
    logic [N_IN*N_OUT*WW-1:0] w;
    logic                     in_valid;
    logic                     out_ready;

    logic                     in_ready1, in_ready0;
    logic [N_OUT*OW-1:0]      y1, y0;
    logic [N_OUT-1:0]         yv1, yv0;
    logic                     ov1, ov0;

    int cyc = 0;
    int checks = 0;
    int passed = 0;

    int xs [N_IN];
    int ws [N_OUT][N_IN];

    fc_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .IW(IW), .WW(WW), .RELU(1)) dut_relu (
        .clk(clk), .rst(rst), .x(x), .w(w), .in_valid(in_valid), .in_ready(in_ready1),
        .y(y1), .y_vld(yv1), .out_valid(ov1), .out_ready(out_ready)
    );

    fc_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .IW(IW), .WW(WW), .RELU(0)) dut_lin (
        .clk(clk), .rst(rst), .x(x), .w(w), .in_valid(in_valid), .in_ready(in_ready0),
        .y(y0), .y_vld(yv0), .out_valid(ov0), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: plain signed dot product with optional clamp.
    function automatic int ref_y(input int o, input bit relu);
        int s = 0;
        for (int i = 0; i < N_IN; i++) s += xs[i] * ws[o][i];
        if (relu && s < 0) s = 0;
        return s;
    endfunction

    task automatic load_inputs();
        int t;
        for (int i = 0; i < N_IN; i++) begin
            t = xs[i];
            x[i*IW +: IW] = t[IW-1:0];
        end
        for (int o = 0; o < N_OUT; o++) begin
            for (int i = 0; i < N_IN; i++) begin
                t = ws[o][i];
                w[(o*N_IN+i)*WW +: WW] = t[WW-1:0];
            end
        end
    endtask

    task automatic set_all(input int xv, input int wv);
        for (int i = 0; i < N_IN; i++) xs[i] = xv;
        for (int o = 0; o < N_OUT; o++)
            for (int i = 0; i < N_IN; i++) ws[o][i] = wv;
    endtask

    task automatic set_random();
        for (int i = 0; i < N_IN; i++) xs[i] = int'($urandom_range(31, 0)) - 16;
        for (int o = 0; o < N_OUT; o++)
            for (int i = 0; i < N_IN; i++) ws[o][i] = int'($urandom_range(31, 0)) - 16;
    endtask

    // One full transaction; must be called with the clock low-phase or just after a release.
    task automatic txn(input string name, input int hold_cyc, output int t0);
        int k_vld0;
        int k_ov;
        int e;
        logic [OW-1:0] ev;
        logic [N_OUT*OW-1:0] ysnap;
        logic [N_OUT-1:0] yvsnap;
        load_inputs();
        in_valid  = 1'b1;
        out_ready = (hold_cyc == 0);
        check({name, ".in_ready_pre"}, in_ready1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        t0       = cyc;
        in_valid = 1'b0;
        k_vld0   = -1;
        k_ov     = -1;
        for (int k = 1; k <= 40; k++) begin
            x        = N_IN*IW'($urandom);
            w        = {$urandom, $urandom, $urandom};
            in_valid = 1'($urandom);
            @(negedge clk);
            if (yv1[0] && k_vld0 < 0) k_vld0 = cyc - t0;
            if (ov1) begin
                k_ov = cyc - t0;
                break;
            end
        end
        in_valid = 1'b0;
        check({name, ".y_vld0_latency"}, k_vld0, N_IN);
        check({name, ".out_valid_latency"}, k_ov, N_IN*N_OUT);
        for (int o = 0; o < N_OUT; o++) begin
            e  = ref_y(o, 1'b1);
            ev = e[OW-1:0];
            check($sformatf("%s.y_relu[%0d]", name, o), y1[o*OW +: OW], ev);
            e  = ref_y(o, 1'b0);
            ev = e[OW-1:0];
            check($sformatf("%s.y_lin[%0d]", name, o), y0[o*OW +: OW], ev);
        end
        check({name, ".y_vld_all"}, {yv1, yv0}, {2*N_OUT{1'b1}});
        check({name, ".in_ready_hold"}, {in_ready1, in_ready0, ov0}, 3'b001);
        ysnap  = y1;
        yvsnap = yv1;
        for (int h = 0; h < hold_cyc; h++) begin
            in_valid = h[0];
            x        = N_IN*IW'($urandom);
            @(negedge clk);
            check($sformatf("%s.hold%0d.out_valid", name, h), ov1, 1'b1);
            check($sformatf("%s.hold%0d.y", name, h), y1, ysnap);
            check($sformatf("%s.hold%0d.y_vld", name, h), yv1, yvsnap);
            check($sformatf("%s.hold%0d.in_ready", name, h), in_ready1, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({name, ".release.out_valid"}, {ov1, ov0}, 2'b00);
        check({name, ".release.y_vld"}, yv1, '0);
        check({name, ".release.in_ready"}, in_ready1, 1'b1);
        check({name, ".release.y_kept"}, y1, ysnap);
    endtask

    initial begin
        int ta;
        int tb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        w         = '0;
        repeat (2) @(negedge clk);
        check("reset.in_ready", {in_ready1, in_ready0}, 2'b11);
        check("reset.out_valid", {ov1, ov0}, 2'b00);
        check("reset.y", {y1, y0}, '0);
        check("reset.y_vld", {yv1, yv0}, '0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Linear sum: x=[1,2,3,4], all weights 1.
        for (int i = 0; i < N_IN; i++) xs[i] = i + 1;
        for (int o = 0; o < N_OUT; o++)
            for (int i = 0; i < N_IN; i++) ws[o][i] = 1;
        txn("linsum", 0, ta);

        // ReLU clamp on neuron 0.
        set_all(1, 2);
        for (int i = 0; i < N_IN; i++) ws[0][i] = -1;
        txn("relu", 0, ta);

        // Extremes.
        set_all(-16, -16);
        txn("ext_nn", 0, ta);
        set_all(-16, 15);
        txn("ext_np", 0, ta);

        // Random vectors, one with 5 cycles of backpressure.
        set_random();
        txn("rand0", 5, ta);
        set_random();
        txn("rand1", 0, ta);

        // Reset in the middle of a run.
        set_all(3, 1);
        load_inputs();
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst.y", {y1, y0}, '0);
        check("midrst.y_vld", {yv1, yv0}, '0);
        check("midrst.out_valid", {ov1, ov0}, 2'b00);
        check("midrst.in_ready", {in_ready1, in_ready0}, 2'b11);
        @(posedge clk);
        #1 rst = 1'b0;
        set_random();
        txn("after_rst", 0, ta);

        // Back-to-back with out_ready held high.
        set_random();
        txn("b2b_a", 0, ta);
        set_random();
        txn("b2b_b", 0, tb);
        check("b2b.accept_spacing", tb - ta, 18);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
